// File: rtl/proc_stream_io.sv
// rtl/proc_stream_io.sv - processor I/O port bridging an inbound and outbound word stream through two FIFOs
// Optional interrupt logic enabled by macro PROC_STREAM_IO_ITR_EN.
module proc_stream_io #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(NUIOIN)-1:0] addr_in,
    input  logic                      req_in,
    output logic [NUBITS-1:0]         io_in,
    input  logic [$clog2(NUIOOU)-1:0] addr_out,
    input  logic                      out_en,
    input  logic [NUBITS-1:0]         io_out,
    output logic                      itr,
    input  logic [NUBITS-1:0]         rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic [NUBITS-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready
);

    localparam int AIW = $clog2(NUIOIN);
    localparam int AOW = $clog2(NUIOOU);
    localparam int PW  = $clog2(FDEPTH);
    localparam int CW  = $clog2(FDEPTH + 1);

    logic [NUBITS-1:0] rx_mem_q [FDEPTH];
    logic [NUBITS-1:0] rx_mem_d [FDEPTH];
    logic [NUBITS-1:0] tx_mem_q [FDEPTH];
    logic [NUBITS-1:0] tx_mem_d [FDEPTH];
    logic [PW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [PW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;

    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic rd_data, wr_data, wr_ctrl, flag_clr;
    logic [NUBITS-1:0] status;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(FDEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(FDEPTH));

    assign rd_data  = req_in & (addr_in == '0);
    assign wr_data  = out_en & (addr_out == '0);
    assign wr_ctrl  = out_en & (addr_out == AOW'(1));
    assign flag_clr = wr_ctrl & io_out[0];

    assign rx_push  = rx_valid & ~rx_full;
    assign rx_pop   = rd_data & ~rx_empty;
    assign tx_push  = wr_data & ~tx_full;
    assign tx_pop   = tx_ready & ~tx_empty;

    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_mem_q[tx_rp_q];

    always_comb begin
        status      = '0;
        status[0]   = rx_empty;
        status[1]   = tx_full;
        status[2]   = ovf_q;
        status[3]   = udf_q;
        status[7:4] = 4'(rx_cnt_q);
    end

    always_comb begin
        io_in = '0;
        if (addr_in == '0) begin
            io_in = rx_empty ? '0 : rx_mem_q[rx_rp_q];
        end else if (addr_in == AIW'(1)) begin
            io_in = status;
        end
    end

    // Count tracks push/pop independently so a simultaneous push and pop cancels out.
    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = rx_data;
            rx_wp_d           = rx_wp_q + PW'(1);
        end
        if (rx_pop) begin
            rx_rp_d = rx_rp_q + PW'(1);
        end
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + CW'(1);
        end else if (rx_pop && !rx_push) begin
            rx_cnt_d = rx_cnt_q - CW'(1);
        end
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = io_out;
            tx_wp_d           = tx_wp_q + PW'(1);
        end
        if (tx_pop) begin
            tx_rp_d = tx_rp_q + PW'(1);
        end
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + CW'(1);
        end else if (tx_pop && !tx_push) begin
            tx_cnt_d = tx_cnt_q - CW'(1);
        end
    end

    // A set in the same cycle as a clear wins.
    always_comb begin
        ovf_d = (ovf_q & ~flag_clr) | (wr_data & tx_full);
        udf_d = (udf_q & ~flag_clr) | (rd_data & rx_empty);
    end

    always_ff @(posedge clk) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
        if (rst) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef PROC_STREAM_IO_ITR_EN
    logic itr_en_q, itr_en_d, itr_q, itr_d;

    always_comb begin
        itr_en_d = itr_en_q;
        if (wr_ctrl) begin
            itr_en_d = io_out[1];
        end
        itr_d = itr_en_q & ~rx_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            itr_en_q <= 1'b0;
            itr_q    <= 1'b0;
        end else begin
            itr_en_q <= itr_en_d;
            itr_q    <= itr_d;
        end
    end

    assign itr = itr_q;
`else
    assign itr = 1'b0;
`endif

endmodule

// File: tb/tb_proc_stream_io.sv
// tb/tb_proc_stream_io.sv - self-checking bench for proc_stream_io against a queue-based reference model
module tb_proc_stream_io;

    localparam int NB = 16;
    localparam int FD = 8;
`ifdef PROC_STREAM_IO_ITR_EN
    localparam bit ITR = 1'b1;
`else
    localparam bit ITR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [0:0]    addr_in;
    logic          req_in;
    logic [NB-1:0] io_in;
    logic [0:0]    addr_out;
    logic          out_en;
    logic [NB-1:0] io_out;
    logic          itr;
    logic [NB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [NB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;

    proc_stream_io #(.NUBITS(NB), .NUIOIN(2), .NUIOOU(2), .FDEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .addr_in(addr_in), .req_in(req_in), .io_in(io_in),
        .addr_out(addr_out), .out_en(out_en), .io_out(io_out),
        .itr(itr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, flags as bits.
    logic [NB-1:0] rxq[$];
    logic [NB-1:0] txq[$];
    bit m_ovf, m_udf, m_itr_en, m_itr, model_valid;
    bit ovf_set, udf_set, clr, itr_next;
    int rn, tn;

    always @(posedge clk) begin
        if (rst) begin
            rxq.delete();
            txq.delete();
            m_ovf = 0; m_udf = 0; m_itr_en = 0; m_itr = 0;
            model_valid = 1;
        end else if (model_valid) begin
            rn = rxq.size();
            tn = txq.size();
            ovf_set = 0; udf_set = 0; clr = 0;
            itr_next = m_itr_en && (rn != 0);
            if (req_in && addr_in == 0) begin
                if (rn != 0) void'(rxq.pop_front());
                else udf_set = 1;
            end
            if (rx_valid && rn < FD) rxq.push_back(rx_data);
            if (tx_ready && tn != 0) void'(txq.pop_front());
            if (out_en && addr_out == 0) begin
                if (tn < FD) txq.push_back(io_out);
                else ovf_set = 1;
            end
            if (out_en && addr_out == 1) begin
                clr = io_out[0];
                if (ITR) m_itr_en = io_out[1];
            end
            m_ovf = (m_ovf && !clr) || ovf_set;
            m_udf = (m_udf && !clr) || udf_set;
            m_itr = ITR && itr_next;
        end
    end

    function automatic logic [NB-1:0] exp_io_in();
        logic [NB-1:0] s;
        s = '0;
        if (addr_in == 0) begin
            if (rxq.size() != 0) s = rxq[0];
        end else begin
            s[0]   = (rxq.size() == 0);
            s[1]   = (txq.size() == FD);
            s[2]   = m_ovf;
            s[3]   = m_udf;
            s[7:4] = 4'(rxq.size());
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            chk("io_in", io_in, exp_io_in());
            chk("rx_ready", rx_ready, rxq.size() < FD);
            chk("tx_valid", tx_valid, txq.size() != 0);
            chk("tx_data", tx_data, (txq.size() != 0) ? txq[0] : 16'h0);
            chk("itr", itr, m_itr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; addr_in = 0; req_in = 0; addr_out = 0; out_en = 0; io_out = 0;
        rx_data = 0; rx_valid = 0; tx_ready = 0;
        step();
        step();
        rst = 0;

        addr_in = 1; #1;
        chk("rst_status", io_in, 16'h0001);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        addr_in = 0; #1;
        chk("rst_rx_head", io_in, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            rx_valid = 1; rx_data = 16'h0011 + 16'(i);
            step();
        end
        rx_valid = 0; addr_in = 1; #1;
        chk("fill_rx_ready", rx_ready, 0);
        chk("fill_status", io_in, 16'h0080);
        for (int i = 0; i < 8; i++) begin
            addr_in = 0; req_in = 1; #1;
            chk("fill_read", io_in, 16'h0011 + 16'(i));
            step();
        end
        req_in = 0; addr_in = 1; #1;
        chk("drain_status", io_in, 16'h0001);

        addr_in = 0; req_in = 1; #1;
        chk("udf_read", io_in, 16'h0000);
        step();
        req_in = 0; addr_in = 1; #1;
        chk("udf_status", io_in, 16'h0009);
        out_en = 1; addr_out = 1; io_out = 16'h0001;
        step();
        out_en = 0; #1;
        chk("udf_cleared", io_in, 16'h0001);

        for (int i = 0; i < 9; i++) begin
            out_en = 1; addr_out = 0; io_out = 16'h0100 + 16'(i);
            step();
        end
        out_en = 0; #1;
        chk("ovf_status", io_in, 16'h0007);
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("ovf_tx_valid", tx_valid, 1);
            chk("ovf_tx_data", tx_data, 16'h0100 + 16'(i));
            step();
        end
        #1;
        chk("tx_drained", tx_valid, 0);
        tx_ready = 0;
        out_en = 1; addr_out = 1; io_out = 16'h0001;
        step();
        out_en = 0;

        for (int i = 0; i < 3; i++) begin
            rx_valid = 1; rx_data = 16'h00A1 + 16'(i);
            step();
        end
        rx_valid = 1; rx_data = 16'h00A4; req_in = 1; addr_in = 0; #1;
        chk("simul_read", io_in, 16'h00A1);
        step();
        rx_valid = 0; req_in = 0; addr_in = 1; #1;
        chk("simul_status", io_in, 16'h0030);
        for (int i = 0; i < 3; i++) begin
            addr_in = 0; req_in = 1; #1;
            chk("simul_order", io_in, 16'h00A2 + 16'(i));
            step();
        end
        req_in = 0;

        out_en = 1; addr_out = 1; io_out = 16'h0002;
        step();
        out_en = 0; rx_valid = 1; rx_data = 16'h0055;
        step();
        rx_valid = 0; #1;
        chk("itr_n1", itr, 0);
        step();
        chk("itr_n2", itr, ITR);
        addr_in = 0; req_in = 1;
        step();
        req_in = 0; #1;
        chk("itr_pop_m1", itr, ITR);
        step();
        chk("itr_pop_m2", itr, 0);
        out_en = 1; addr_out = 1; io_out = 16'h0000;
        step();
        out_en = 0;

        rx_valid = 1; rx_data = 16'h0077; out_en = 1; addr_out = 0; io_out = 16'h0088;
        step();
        step();
        rx_valid = 0; out_en = 0; rst = 1;
        step();
        rst = 0; addr_in = 1; #1;
        chk("midrst_status", io_in, 16'h0001);
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_tx_data", tx_data, 0);

        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            rx_valid = $urandom_range(0, 1);
            rx_data  = NB'($urandom);
            req_in   = ($urandom_range(0, 2) == 0);
            addr_in  = 1'($urandom);
            out_en   = $urandom_range(0, 1);
            addr_out = ($urandom_range(0, 3) == 0);
            io_out   = NB'($urandom);
            tx_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst = 0; rx_valid = 0; req_in = 0; out_en = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_stream_io.md
PROC_STREAM_IO -- requirements
Module: proc_stream_io

Interface
REQ-001 The block SHALL have parameter NUBITS, default 16, meaning processor word width and stream data width.
REQ-002 The block SHALL have parameter NUIOIN, default 2, meaning the number of processor input addresses (minimum 2).
REQ-003 The block SHALL have parameter NUIOOU, default 2, meaning the number of processor output addresses (minimum 2).
REQ-004 The block SHALL have parameter FDEPTH, default 8, meaning the depth of each FIFO (power of 2, range 2..8).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port addr_in, input, $clog2(NUIOIN) bits: processor read address.
REQ-008 The block SHALL have port req_in, input, 1 bit: processor read strobe.
REQ-009 The block SHALL have port io_in, output, NUBITS bits: read data returned to the processor.
REQ-010 The block SHALL have port addr_out, input, $clog2(NUIOOU) bits: processor write address.
REQ-011 The block SHALL have port out_en, input, 1 bit: processor write strobe.
REQ-012 The block SHALL have port io_out, input, NUBITS bits: processor write data.
REQ-013 The block SHALL have port itr, output, 1 bit: interrupt request to the processor.
REQ-014 The block SHALL have ports rx_data (input, NUBITS), rx_valid (input, 1) and rx_ready (output, 1) forming the external inbound stream.
REQ-015 The block SHALL have ports tx_data (output, NUBITS), tx_valid (output, 1) and tx_ready (input, 1) forming the external outbound stream.

Function
REQ-016 The RX FIFO SHALL push rx_data on a rising edge where rx_valid and rx_ready are both 1, with rx_ready = ~rx_full.
REQ-017 io_in SHALL be combinational from addr_in, independent of req_in:
- addr 0 returns the RX head, or 0 if RX is empty.
- addr 1 returns the status word.
- other addresses return 0.
REQ-018 A rising edge with req_in=1 and addr_in=0 SHALL pop RX when it is non-empty; when RX is empty it SHALL instead set the sticky UDF flag.
REQ-019 The status word SHALL be laid out as: bit0 rx_empty, bit1 tx_full, bit2 OVF, bit3 UDF, bits[7:4] RX count (0..FDEPTH), upper bits 0.
REQ-020 A rising edge with out_en=1 and addr_out=0 SHALL push io_out into TX when TX is not full; when TX is full the word SHALL be dropped and the sticky OVF flag set, even if TX pops in the same cycle.
REQ-021 A write to addr_out=1 SHALL act as a control write:
- bit0=1 clears OVF and UDF.
- bit1 is loaded into register itr_en.
REQ-022 Writes to addr_out >= 2 SHALL be ignored.
REQ-023 TX outputs SHALL be driven as tx_valid = ~tx_empty and tx_data = TX head; TX SHALL pop on an edge where tx_valid and tx_ready are both 1.
REQ-024 A simultaneous push and pop on the same FIFO (not full, not empty) SHALL leave its count unchanged and preserve order.
REQ-025 Latency: an RX word accepted at edge N SHALL be readable on io_in from cycle N+1; a TX word written at edge N SHALL give tx_valid=1 from cycle N+1.
REQ-026 Read and write pointers SHALL wrap modulo FDEPTH; the count SHALL saturate at neither 0 nor FDEPTH incorrectly (full exactly at FDEPTH, empty exactly at 0).
REQ-027 itr SHALL be a registered output equal to itr_en & ~rx_empty evaluated at the previous edge.
REQ-028 A UDF set and a clear in the same cycle SHALL resolve to the flag set; the same SHALL apply to an OVF set and a clear in the same cycle.

Reset
REQ-029 While rst=1 at an edge, the block SHALL:
- empty both FIFOs (pointers and counts to 0);
- clear OVF, UDF, itr_en and itr;
- ignore pushes, pops and control writes in that cycle.
REQ-030 After reset the outputs SHALL be rx_ready=1, tx_valid=0, tx_data=0 and io_in=0 (addr 0) or 0x0001 (addr 1). A reset mid-stream discards all buffered words.

Configuration
REQ-031 The block SHALL support macro PROC_STREAM_IO_ITR_EN:
- When defined, the itr_en register and the itr logic SHALL exist as specified in REQ-021 and REQ-027.
- When undefined, itr SHALL be tied to 0 and control bit1 SHALL be ignored.

Verification
REQ-032 Reset and status scenario: assert rst for 2 cycles, then read addr 1 -> io_in=0x0001, rx_ready=1, tx_valid=0.
REQ-033 RX fill scenario: push 8 words 0x0011..0x0018 via rx_valid -> rx_ready=0 after the 8th, status=0x0080; 8 reads at addr 0 return 0x0011..0x0018 in order, then status=0x0001.
REQ-034 Underflow scenario: read addr 0 while RX is empty -> io_in=0, status bit3=1; write 0x0001 to addr 1 -> bit3=0.
REQ-035 TX overflow scenario: hold tx_ready=0 and write 9 words 0x0100..0x0108 -> 9th dropped, status bits1,2 set; release tx_ready -> 0x0100..0x0107 appear on tx_data, one per cycle.
REQ-036 Interrupt scenario (macro defined): write 0x0002 to addr 1, then push one RX word at edge N -> itr=1 from cycle N+2; pop it -> itr=0 one cycle after the RX FIFO becomes empty.
REQ-037 Simultaneous-event scenario: with RX holding 3 words, push and pop in the same cycle -> count stays 3 and the read returns the oldest word.
